sample_scheduler: RTL and testbench

Sample-rate scheduler and ring-buffer controller between the mixer and the audio outputs (DAC modulator and Avalon-ST source). It generates the sample-rate tick as a clock enable, buffers mixed samples in a DEPTH-entry ring, and gates the generator pipeline (`clk_en` of bank manager and mixer) with watermark hysteresis. It also detects and counts underruns and overflows. One clock domain; the DAC consumes `o_dac_sample` qualified by `o_tick`.

---
 rtl/sample_scheduler.sv | 172 +++++++++++++++++
 tb/tb_sample_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_scheduler.sv
// Sample-rate scheduler: tick divider, DEPTH-entry sample ring, watermark-gated generator enable.
// Optional build macro SCHED_UNDERRUN_HOLD_EN: silence repeats the last output sample instead of 0.
module sample_scheduler #(
  parameter int WIDTH   = 24,
  parameter int DEPTH   = 128,
  parameter int CLK_DIV = 521,
  parameter int HI_WM   = 96,
  parameter int LO_WM   = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [WIDTH-1:0]         i_sample,
  input  logic                     i_sample_vld,
  input  logic                     i_flush,
  output logic                     o_gen_en,
  output logic                     o_tick,
  output logic [WIDTH-1:0]         o_dac_sample,
  output logic [31:0]              aso_ss0_data,
  output logic                     aso_ss0_valid,
  input  logic                     aso_ss0_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_underrun_cnt,
  output logic [15:0]              o_overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_gen_en;
  logic [WIDTH-1:0] r_dac;
  logic             r_valid;
  logic [15:0]      r_underrun_cnt;
  logic [15:0]      r_overflow_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_tick;
  logic             w_active_tick;
  logic             w_empty;
  logic             w_full;
  logic             w_rd;
  logic             w_underrun;
  logic             w_wr_req;
  logic             w_wr;
  logic             w_drop;
  logic             w_at_hi;
  logic             w_at_lo;
  logic [WIDTH-1:0] w_silence;
  logic [1:0]       w_state_next;
  logic             w_gen_en_next;

  assign w_tick        = (r_div == DIV_W'(CLK_DIV - 1));
  // A flush request or the flush cycle itself swallows the tick.
  assign w_active_tick = w_tick && !i_flush && (r_state != ST_FLUSH);
  assign w_empty       = (r_level == '0);
  assign w_full        = (r_level == LVL_W'(DEPTH));
  assign w_rd          = w_active_tick && (r_state == ST_RUN) && !w_empty;
  assign w_underrun    = w_active_tick && (r_state == ST_RUN) && w_empty;
  assign w_wr_req      = i_sample_vld && !i_flush && (r_state != ST_FLUSH);
  assign w_wr          = w_wr_req && (!w_full || w_rd);
  assign w_drop        = w_wr_req && w_full && !w_rd;
  assign w_at_hi       = (r_level >= LVL_W'(HI_WM));
  assign w_at_lo       = (r_level <= LVL_W'(LO_WM));

`ifdef SCHED_UNDERRUN_HOLD_EN
  assign w_silence = r_dac;
`else
  assign w_silence = '0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_gen_en_next = r_gen_en;
    if (i_flush) begin
      w_state_next  = ST_FLUSH;
      w_gen_en_next = 1'b0;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (w_at_hi) begin
            w_state_next  = ST_RUN;
            w_gen_en_next = 1'b0;
          end else begin
            w_gen_en_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_underrun) begin
            w_state_next  = ST_PRIME;
            w_gen_en_next = 1'b1;
          end else if (w_at_hi) begin
            w_gen_en_next = 1'b0;
          end else if (w_at_lo) begin
            w_gen_en_next = 1'b1;
          end
        end
        ST_FLUSH: begin
          w_state_next  = ST_PRIME;
          w_gen_en_next = 1'b1;
        end
        default: begin
          w_state_next  = ST_PRIME;
          w_gen_en_next = 1'b0;
        end
      endcase
    end
  end

  // Ring storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div          <= '0;
      r_state        <= ST_PRIME;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_gen_en       <= 1'b0;
      r_dac          <= '0;
      r_valid        <= 1'b0;
      r_underrun_cnt <= '0;
      r_overflow_cnt <= '0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
      r_state  <= w_state_next;
      r_gen_en <= w_gen_en_next;

      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_wr && !w_rd)      r_level <= r_level + LVL_W'(1);
        else if (w_rd && !w_wr) r_level <= r_level - LVL_W'(1);
      end

      if (w_rd)               r_dac <= r_mem[r_rd_ptr];
      else if (w_active_tick) r_dac <= w_silence;

      // A tick update wins over a handshake in the same cycle so new data is never lost.
      if (w_active_tick)               r_valid <= 1'b1;
      else if (r_valid && aso_ss0_ready) r_valid <= 1'b0;

      if (w_underrun && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (w_drop && (r_overflow_cnt != 16'hFFFF))     r_overflow_cnt <= r_overflow_cnt + 16'd1;
    end
  end

  assign o_tick         = w_tick;
  assign o_gen_en       = r_gen_en;
  assign o_dac_sample   = r_dac;
  assign aso_ss0_data   = 32'($signed(r_dac));
  assign aso_ss0_valid  = r_valid;
  assign o_level        = r_level;
  assign o_underrun_cnt = r_underrun_cnt;
  assign o_overflow_cnt = r_overflow_cnt;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler with DEPTH=16, HI_WM=12, LO_WM=4, CLK_DIV=8.
module tb_sample_scheduler;

  logic        clk;
  logic        n_rst;
  logic [23:0] i_sample;
  logic        i_sample_vld;
  logic        i_flush;
  logic        o_gen_en;
  logic        o_tick;
  logic [23:0] o_dac_sample;
  logic [31:0] aso_ss0_data;
  logic        aso_ss0_valid;
  logic        aso_ss0_ready;
  logic [4:0]  o_level;
  logic [15:0] o_underrun_cnt;
  logic [15:0] o_overflow_cnt;

  sample_scheduler #(
    .WIDTH(24), .DEPTH(16), .CLK_DIV(8), .HI_WM(12), .LO_WM(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_sample(i_sample), .i_sample_vld(i_sample_vld),
    .i_flush(i_flush), .o_gen_en(o_gen_en), .o_tick(o_tick), .o_dac_sample(o_dac_sample),
    .aso_ss0_data(aso_ss0_data), .aso_ss0_valid(aso_ss0_valid), .aso_ss0_ready(aso_ss0_ready),
    .o_level(o_level), .o_underrun_cnt(o_underrun_cnt), .o_overflow_cnt(o_overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] data_ctr;
  logic [23:0] out_q[$];
  logic        val_q[$];
  logic        auto_mode;
  logic        man_vld;
  logic [23:0] exp_silence;
  int          exp_ovf;
  logic        found;
  int          k;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok  %s = %0h", tag, got);
    end
  endtask

  // One clock: record the output sample produced by last cycle's tick, then drive this cycle.
  task automatic step();
    logic tick_prev;
    tick_prev = o_tick && !i_flush;
    @(posedge clk); #1;
    if (i_sample_vld) data_ctr++;
    if (tick_prev && n_rst) begin
      out_q.push_back(o_dac_sample);
      val_q.push_back(aso_ss0_valid);
    end
    i_flush      = 1'b0;
    i_sample_vld = auto_mode ? o_gen_en : man_vld;
    i_sample     = data_ctr;
  endtask

  task automatic do_reset(input string tag);
    #2 n_rst = 1'b0;
    #1;
    check_value({tag, "_gen_en"}, {31'd0, o_gen_en}, 32'd0);
    check_value({tag, "_dac"}, {8'd0, o_dac_sample}, 32'd0);
    check_value({tag, "_aso_data"}, aso_ss0_data, 32'd0);
    check_value({tag, "_valid"}, {31'd0, aso_ss0_valid}, 32'd0);
    check_value({tag, "_level"}, {27'd0, o_level}, 32'd0);
    check_value({tag, "_urun"}, {16'd0, o_underrun_cnt}, 32'd0);
    check_value({tag, "_ovf"}, {16'd0, o_overflow_cnt}, 32'd0);
    check_value({tag, "_tick"}, {31'd0, o_tick}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_ctr = 24'd1;
    out_q.delete();
    val_q.delete();
    i_flush      = 1'b0;
    i_sample     = data_ctr;
    i_sample_vld = auto_mode ? 1'b0 : man_vld;
    n_rst        = 1'b1;
  endtask

  task automatic wait_level(input int lvl, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_level == 5'(lvl)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check_value({tag, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_outs(input int n, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_q.size() >= n) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check_value({tag, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    n_rst = 1'b1; i_sample = '0; i_sample_vld = 1'b0; i_flush = 1'b0;
    aso_ss0_ready = 1'b1; auto_mode = 1'b1; man_vld = 1'b0; data_ctr = 24'd1;
    @(posedge clk); #1;

    // Prime
    do_reset("por");
    check_value("c0_gen_en", {31'd0, o_gen_en}, 32'd0);
    step();
    check_value("c1_gen_en", {31'd0, o_gen_en}, 32'd1);
    k = 1;
    while (!o_tick && k < 20) begin
      step();
      k++;
    end
    check_value("first_tick_cycle", k, 32'd7);
    wait_level(12, 40, "prime_lvl12");
    step();
    if (o_gen_en) step();
    check_value("prime_gen_en_drop", {31'd0, o_gen_en}, 32'd0);
    wait_outs(4, 40, "prime_outs");
    check_value("prime_silence", {8'd0, out_q[0]}, 32'd0);
    check_value("prime_silence_valid", {31'd0, val_q[0]}, 32'd1);
    check_value("run_out0", {8'd0, out_q[1]}, 32'd1);
    check_value("run_out1", {8'd0, out_q[2]}, 32'd2);
    check_value("run_out2", {8'd0, out_q[3]}, 32'd3);

    // Hysteresis
    wait_level(4, 200, "hyst_lvl4");
    check_value("hyst_lo_gen_before", {31'd0, o_gen_en}, 32'd0);
    step();
    check_value("hyst_lo_gen_after", {31'd0, o_gen_en}, 32'd1);
    wait_level(12, 60, "hyst_lvl12");
    check_value("hyst_hi_gen_before", {31'd0, o_gen_en}, 32'd1);
    step();
    check_value("hyst_hi_gen_after", {31'd0, o_gen_en}, 32'd0);
    wait_outs(16, 200, "hyst_outs");
    for (int i = 4; i < 16; i++)
      check_value($sformatf("contig_out%0d", i), {8'd0, out_q[i]}, i);

    // Underrun
    auto_mode = 1'b0; man_vld = 1'b0; i_sample_vld = 1'b0;
`ifdef SCHED_UNDERRUN_HOLD_EN
    exp_silence = data_ctr - 24'd1;
`else
    exp_silence = 24'd0;
`endif
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_tick && o_level == 5'd0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_value("urun_reached", {31'd0, found}, 32'd1);
    check_value("urun_last_drained", {8'd0, out_q[$]}, {8'd0, data_ctr - 24'd1});
    step();
    check_value("urun_cnt", {16'd0, o_underrun_cnt}, 32'd1);
    check_value("urun_silence", {8'd0, o_dac_sample}, {8'd0, exp_silence});
    check_value("urun_valid", {31'd0, aso_ss0_valid}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_tick) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_value("prime_tick_reached", {31'd0, found}, 32'd1);
    step();
    check_value("prime_no_urun", {16'd0, o_underrun_cnt}, 32'd1);
    check_value("prime_silence2", {8'd0, o_dac_sample}, {8'd0, exp_silence});

    // Flush
    auto_mode = 1'b1; i_sample_vld = o_gen_en;
    wait_level(9, 30, "flush_lvl9");
    i_flush = 1'b1;
    step();
    check_value("flush_level", {27'd0, o_level}, 32'd0);
    check_value("flush_gen_en", {31'd0, o_gen_en}, 32'd0);
    check_value("flush_urun_kept", {16'd0, o_underrun_cnt}, 32'd1);
    step();
    check_value("flush_prime_gen_en", {31'd0, o_gen_en}, 32'd1);
    check_value("flush_prime_level", {27'd0, o_level}, 32'd0);
    step();
    check_value("flush_refill_level", {27'd0, o_level}, 32'd1);

    // Overflow (asynchronous reset mid-operation)
    auto_mode = 1'b0; man_vld = 1'b1;
    do_reset("arst");
    wait_level(16, 40, "ovf_full");
    exp_ovf = 0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_tick) begin
        found = 1'b1;
        break;
      end
      exp_ovf++;
      step();
      check_value($sformatf("ovf_cnt_%0d", exp_ovf), {16'd0, o_overflow_cnt}, exp_ovf);
    end
    check_value("ovf_tick_reached", {31'd0, found}, 32'd1);
    step();
    check_value("ovf_tick_level", {27'd0, o_level}, 32'd16);
    check_value("ovf_tick_accepted", {16'd0, o_overflow_cnt}, exp_ovf);
    check_value("ovf_total", {16'd0, o_overflow_cnt}, 32'd6);
    check_value("ovf_tick_sample", {8'd0, o_dac_sample}, 32'd2);
    man_vld = 1'b0;

    // Backpressure (negative samples exercise sign extension)
    auto_mode = 1'b1;
    do_reset("bp_rst");
    data_ctr = 24'h800000; i_sample = data_ctr;
    wait_outs(2, 40, "bp_outs2");
    aso_ss0_ready = 1'b0;
    wait_outs(4, 30, "bp_outs4");
    check_value("bp_valid_held", {31'd0, aso_ss0_valid}, 32'd1);
    check_value("bp_dac", {8'd0, o_dac_sample}, 32'h00800002);
    check_value("bp_aso_data", aso_ss0_data, 32'hFF800002);
    step();
    check_value("bp_valid_still", {31'd0, aso_ss0_valid}, 32'd1);
    aso_ss0_ready = 1'b1;
    step();
    aso_ss0_ready = 1'b0;
    check_value("bp_valid_cleared", {31'd0, aso_ss0_valid}, 32'd0);
    step();
    check_value("bp_valid_stays_low", {31'd0, aso_ss0_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
